// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, line constants and default widths
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;

    localparam int DEFAULT_DWIDTH = 8;
    localparam int DEFAULT_PWIDTH = 6;

    // data_xor is the XOR-reduction of the payload; odd parity inverts it
    function automatic logic parity_bit(input logic data_xor, input logic par_typ);
        return data_xor ^ (par_typ == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_tx_serializer_if.sv
// rtl/uart_tx_serializer_if.sv - host-side request/configuration bundle for the UART transmitter
//   prescale   : clocks per bit (0 treated as 1)
//   p_data     : byte to send
//   data_valid : send request, honoured only while busy=0
//   par_en     : insert parity bit
//   par_typ    : 0 even, 1 odd
//   busy       : frame in progress (from transmitter)
interface uart_tx_serializer_if #(
    parameter int DWIDTH = 8,
    parameter int PWIDTH = 6
);
    logic [PWIDTH-1:0] prescale;
    logic [DWIDTH-1:0] p_data;
    logic              data_valid;
    logic              par_en;
    logic              par_typ;
    logic              busy;

    modport master (
        output prescale, p_data, data_valid, par_en, par_typ,
        input  busy
    );

    modport slave (
        input  prescale, p_data, data_valid, par_en, par_typ,
        output busy
    );
endinterface

// File: rtl/tx_edge_counter.sv
// rtl/tx_edge_counter.sv - per-bit clock counter, pulses bit_done on the last clock of each bit
//   clk, rst : clock, synchronous active-high reset
//   en       : count while a frame is in progress; held at 0 otherwise
//   period   : latched clocks per bit (never 0)
//   bit_done : high during the final clock of the current bit
module tx_edge_counter #(
    parameter int PWIDTH = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [PWIDTH-1:0] period,
    output logic              bit_done
);

    logic [PWIDTH-1:0] count;

    assign bit_done = en && (count == period - PWIDTH'(1));

    // Clearing while disabled guarantees the first bit of a frame starts at 0
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            count <= '0;
        end else if (bit_done) begin
            count <= '0;
        end else begin
            count <= count + PWIDTH'(1);
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - UART frame serializer: start, data LSB first, optional parity, stop
//   clk, rst : clock, synchronous active-high reset
//   host     : request/configuration bundle (slave side), busy returned on it
//   tx_out   : serial line, registered, idles high
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DWIDTH = DEFAULT_DWIDTH,
    parameter int PWIDTH = DEFAULT_PWIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_tx_serializer_if.slave  host,
    output logic                 tx_out
);

    localparam int IWIDTH = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;

    tx_state_t         state;
    logic [DWIDTH-1:0] shift_r;
    logic [IWIDTH-1:0] bit_idx;
    logic [PWIDTH-1:0] period;
    logic              par_en_r;
    logic              par_bit;
    logic              busy_r;
    logic              bit_done;

    tx_edge_counter #(
        .PWIDTH (PWIDTH)
    ) u_edge_counter (
        .clk      (clk),
        .rst      (rst),
        .en       (state != IDLE),
        .period   (period),
        .bit_done (bit_done)
    );

    assign host.busy = busy_r;

    // Everything the frame depends on is captured at accept, so host-side
    // changes during a frame cannot disturb it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tx_out   <= STOP_BIT;
            busy_r   <= 1'b0;
            bit_idx  <= '0;
            shift_r  <= '0;
            period   <= PWIDTH'(1);
            par_en_r <= 1'b0;
            par_bit  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    tx_out <= STOP_BIT;
                    busy_r <= 1'b0;
                    if (host.data_valid) begin
                        shift_r  <= host.p_data;
                        par_en_r <= host.par_en;
                        par_bit  <= parity_bit(^host.p_data, host.par_typ);
                        period   <= (host.prescale == '0) ? PWIDTH'(1) : host.prescale;
                        bit_idx  <= '0;
                        state    <= START;
                        tx_out   <= START_BIT;
                        busy_r   <= 1'b1;
                    end
                end
                START: begin
                    if (bit_done) begin
                        state   <= DATA;
                        tx_out  <= shift_r[0];
                        shift_r <= shift_r >> 1;
                        bit_idx <= '0;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        if (bit_idx == IWIDTH'(DWIDTH - 1)) begin
                            if (par_en_r) begin
                                state  <= PARITY;
                                tx_out <= par_bit;
                            end else begin
                                state  <= STOP;
                                tx_out <= STOP_BIT;
                            end
                        end else begin
                            bit_idx <= bit_idx + IWIDTH'(1);
                            tx_out  <= shift_r[0];
                            shift_r <= shift_r >> 1;
                        end
                    end
                end
                PARITY: begin
                    if (bit_done) begin
                        state  <= STOP;
                        tx_out <= STOP_BIT;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        state  <= IDLE;
                        tx_out <= STOP_BIT;
                        busy_r <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    tx_out <= STOP_BIT;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb/tb_uart_tx_serializer.sv - self-checking bench for uart_tx_serializer
module tb_uart_tx_serializer;

    logic clk;
    logic rst;
    logic tx_out;

    uart_tx_serializer_if #(.DWIDTH(8), .PWIDTH(6)) hif ();

    uart_tx_serializer #(.DWIDTH(8), .PWIDTH(6)) dut (
        .clk    (clk),
        .rst    (rst),
        .host   (hif),
        .tx_out (tx_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_tests = 0;
    int    n_fail  = 0;
    string cur     = "init";

    typedef struct {
        logic [7:0]  d;
        logic        pen;
        logic        ptyp;
        logic [5:0]  psc;
        logic [10:0] bits;   // bits[i] is the i-th bit put on the line
        int          nbits;
    } vec_t;

    vec_t vecs[4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string what, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s %s: got %b expected %b at %0t", cur, what, act, exp, $time);
        end
    endtask

    // Frame as a list of line bits, straight from the frame format
    function automatic void model_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                                        output logic [10:0] bits, output int nbits);
        bits    = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1 + i] = d[i];
        nbits = 9;
        if (pen) begin
            bits[9] = (^d) ^ ptyp;
            nbits   = 10;
        end
        bits[nbits] = 1'b1;
        nbits       = nbits + 1;
    endfunction

    // Issues a one-cycle request on an idle line, then checks every clock of the frame.
    // inject_at: clock index at which a conflicting request/config change is pulsed.
    // rst_at   : clock index at which reset is pulsed; the frame is then expected dead.
    task automatic run_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                             input logic [5:0] psc, input logic [10:0] bits, input int nbits,
                             input int inject_at, input int rst_at);
        int p;
        p = (psc == 6'd0) ? 1 : int'(psc);
        hif.p_data     = d;
        hif.par_en     = pen;
        hif.par_typ    = ptyp;
        hif.prescale   = psc;
        hif.data_valid = 1'b1;
        tick();
        hif.data_valid = 1'b0;
        for (int k = 0; k < nbits * p; k++) begin
            check($sformatf("tx[%0d]", k), tx_out, bits[k / p]);
            check($sformatf("busy[%0d]", k), hif.busy, 1'b1);
            if (k == inject_at) begin
                hif.data_valid = 1'b1;
                hif.p_data     = 8'hFF;
                hif.prescale   = 6'd8;
                hif.par_en     = ~pen;
                hif.par_typ    = ~ptyp;
            end else if (k == inject_at + 1) begin
                hif.data_valid = 1'b0;
            end
            if (k == rst_at) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                for (int j = 0; j < 6; j++) begin
                    check($sformatf("tx_after_rst[%0d]", j), tx_out, 1'b1);
                    check($sformatf("busy_after_rst[%0d]", j), hif.busy, 1'b0);
                    tick();
                end
                return;
            end
            tick();
        end
        check("tx_end", tx_out, 1'b1);
        check("busy_end", hif.busy, 1'b0);
    endtask

    initial begin
        logic [10:0] mb;
        int          mn;

        vecs[0] = '{d: 8'hA5, pen: 1'b0, ptyp: 1'b0, psc: 6'd4, bits: 11'b11101001010, nbits: 10};
        vecs[1] = '{d: 8'h80, pen: 1'b1, ptyp: 1'b0, psc: 6'd1, bits: 11'b11100000000, nbits: 11};
        vecs[2] = '{d: 8'hA5, pen: 1'b1, ptyp: 1'b1, psc: 6'd2, bits: 11'b11101001010, nbits: 11};
        vecs[3] = '{d: 8'h55, pen: 1'b0, ptyp: 1'b0, psc: 6'd0, bits: 11'b11010101010, nbits: 10};

        // Reset dominates a simultaneous request
        rst            = 1'b1;
        hif.data_valid = 1'b1;
        hif.p_data     = 8'h00;
        hif.prescale   = 6'd1;
        hif.par_en     = 1'b0;
        hif.par_typ    = 1'b0;
        tick();
        cur = "reset";
        check("tx", tx_out, 1'b1);
        check("busy", hif.busy, 1'b0);
        tick();
        rst            = 1'b0;
        hif.data_valid = 1'b0;
        tick();
        check("tx_idle", tx_out, 1'b1);
        check("busy_idle", hif.busy, 1'b0);

        for (int i = 0; i < 4; i++) begin
            cur = $sformatf("vec%0d", i);
            run_frame(vecs[i].d, vecs[i].pen, vecs[i].ptyp, vecs[i].psc,
                      vecs[i].bits, vecs[i].nbits, -1, -1);
            tick();
        end

        // Request and config change mid-frame are ignored; next frame accepted on the first idle cycle
        cur = "busy_ignore";
        model_frame(8'h3C, 1'b0, 1'b0, mb, mn);
        run_frame(8'h3C, 1'b0, 1'b0, 6'd4, mb, mn, 10, -1);
        cur = "back_to_back";
        model_frame(8'h5A, 1'b1, 1'b0, mb, mn);
        run_frame(8'h5A, 1'b1, 1'b0, 6'd3, mb, mn, -1, -1);
        tick();

        // Reset during data bit 3 (clocks 16..19 at prescale 4)
        cur = "rst_mid";
        model_frame(8'hC3, 1'b1, 1'b1, mb, mn);
        run_frame(8'hC3, 1'b1, 1'b1, 6'd4, mb, mn, -1, 17);
        cur = "after_rst";
        model_frame(8'h96, 1'b1, 1'b0, mb, mn);
        run_frame(8'h96, 1'b1, 1'b0, 6'd2, mb, mn, -1, -1);

        for (int r = 0; r < 20; r++) begin
            logic [7:0] d;
            logic       pen;
            logic       ptyp;
            logic [5:0] psc;
            int         gap;
            d    = 8'($urandom);
            pen  = 1'($urandom);
            ptyp = 1'($urandom);
            psc  = 6'($urandom_range(0, 7));
            gap  = int'($urandom_range(0, 3));
            cur  = $sformatf("rand%0d_d%02h_p%0d_pe%0d_pt%0d", r, d, psc, pen, ptyp);
            for (int g = 0; g < gap; g++) begin
                check("gap_tx", tx_out, 1'b1);
                check("gap_busy", hif.busy, 1'b0);
                tick();
            end
            model_frame(d, pen, ptyp, mb, mn);
            run_frame(d, pen, ptyp, psc, mb, mn, (r % 3 == 0) ? 1 : -1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- UART transmit path: the counterpart to the RX data-sampling chain.
- Accepts a parallel byte through a valid/busy handshake and serializes it as a frame: start bit, DWIDTH data bits LSB first, optional parity bit, one stop bit.
- Each bit is held for `prescale` clocks, so TX and RX share the same system clock and prescale setting.
- Sits between the host-side TX register and the tx pad.

Parameters:
- DWIDTH, 8, data bits per frame.
- PWIDTH, 6, width of the prescale input and the internal edge counter.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- prescale  input  PWIDTH  clocks per bit; value 0 treated as 1.
- p_data  input  DWIDTH  byte to transmit.
- data_valid  input  1  request to send p_data.
- par_en  input  1  1 = insert parity bit.
- par_typ  input  1  0 = even parity, 1 = odd parity.
- tx_out  output  1  serial line, registered, idles high.
- busy  output  1  frame in progress; registered.

Behaviour:
- Reset: one clock is synchronous, active-high.
  - Reset values: tx_out=1, busy=0, state=IDLE, edge counter=0, bit index=0.
  - Reset asserted mid-frame aborts the frame. tx_out=1 and busy=0 from the next edge; no partial frame resumes.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx_out=1, busy=0.
  - If data_valid=1 at a rising edge, the following are latched in that cycle: p_data, par_en, par_typ, prescale (0 stored as 1).
  - Parity is computed from the latched data: even = XOR of bits; odd = inverted XOR.
  - Transition to START. From the next edge, tx_out=0 and busy=1.
  - Latency from accept edge to start bit on the line: 1 clock.
- Edge counter:
  - Counts 0..P-1 within each bit, where P is the latched prescale.
  - On count P-1 the counter wraps to 0 and the state/bit advances.
  - Every bit occupies exactly P clocks of tx_out.
- START: tx_out=0 for P clocks, then DATA with bit index 0.
- DATA:
  - tx_out = data[index] for P clocks; index increments.
  - After index DWIDTH-1: go to PARITY if the latched par_en=1, else STOP.
- PARITY: tx_out = computed parity for P clocks, then STOP.
- STOP:
  - tx_out=1 for P clocks, busy still 1.
  - Then IDLE, where busy=0 on the next edge.
- Frame length: (DWIDTH+2+par_en)·P clocks of busy=1.
- Handshake rules:
  - data_valid while busy=1 is ignored. No queueing and no side effect.
  - The earliest next accept is the first IDLE cycle, giving a minimum 1-clock idle gap between frames.
- Configuration changes: changes to prescale, par_en, par_typ or p_data during a frame have no effect until the next accept.
- tx_out is driven directly from a flop: no glitches, no combinational path from the inputs.

Decomposition:
- Shared package uart_pkg holds:
  - TX state enum (IDLE, START, DATA, PARITY, STOP).
  - Constants START_BIT=1'b0 and STOP_BIT=1'b1.
  - Parity-type encodings PAR_EVEN=1'b0 and PAR_ODD=1'b1.
  - Defaults DWIDTH=8 and PWIDTH=6, shared with the RX blocks.
- One sub-module, tx_edge_counter:
  - Holds a PWIDTH counter with enable, wrapping at latched P-1.
  - Outputs a bit_done pulse.
  - Mirrors the RX edge counter.
- FSM, shift/index logic and parity stay in the top module.

Test Plan:
- Basic frame: DWIDTH=8, prescale=4, par_en=0, p_data=0xA5, 1-cycle data_valid.
  - tx_out from the next edge: 0,1,0,1,0,0,1,0,1,1, each held exactly 4 clocks.
  - busy high for 40 clocks, then 0.
- Even parity: prescale=1, par_en=1, par_typ=0, p_data=0x80.
  - Sequence: 0,0,0,0,0,0,0,0,1,1,1. Parity is 1; frame is 11 clocks.
- Odd parity: prescale=2, par_en=1, par_typ=1, p_data=0xA5.
  - Parity bit is 1; busy high for 22 clocks.
- Busy-ignore and config freeze: start 0x3C with prescale=4.
  - Mid-frame, pulse data_valid with 0xFF and change prescale to 8.
  - Frame 0x3C completes unchanged with 4-clock bits; 0xFF is never sent.
  - A new data_valid on the first IDLE cycle starts its start bit 1 clock later.
- Reset mid-frame: assert rst for 1 clock during DATA bit 3.
  - tx_out=1 and busy=0 on the next edge and stay idle.
  - A following request sends a complete, correct frame.
- prescale=0 with p_data=0x55, par_en=0: behaves exactly as prescale=1, giving a 10-clock frame.
